// File: rtl/router_psum_load_pkg.sv
// Shared definitions for the psum load and psum write-back routers.
// Holds the FSM encoding and the default GLB psum layout used by both routers.
package router_psum_load_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        READ_GLB = 3'b001,
        DRAIN    = 3'b010,
        PRESENT  = 3'b011
    } psum_ld_state_e;

    localparam int PSUM_DATA_BITWIDTH     = 16;
    localparam int PSUM_ADDR_BITWIDTH_GLB = 10;
    localparam int PSUM_X_DIM             = 5;
    localparam int PSUM_READ_ADDR_DEF     = 0;

endpackage

// File: rtl/router_psum_load.sv
// Psum load router: reads X_dim psums of one row from the GLB psum region,
// packs them into one wide word and hands it to the PE cluster spads.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   load_psum_ctrl        - start request, sampled only in IDLE
//   r_data_glb_psum       - GLB read data (1-cycle read latency)
//   r_addr_glb_psum       - GLB read address
//   read_en_glb_psum      - GLB read enable
//   w_data_spad_psum      - packed psums, slot k at [k*DATA_BITWIDTH +: DATA_BITWIDTH]
//   psum_load_valid       - packed word valid
//   psum_load_ack         - PE cluster accepted the word
//   busy                  - high whenever the FSM is not IDLE
module router_psum_load
    import router_psum_load_pkg::*;
#(
    parameter int DATA_BITWIDTH     = PSUM_DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH_GLB = PSUM_ADDR_BITWIDTH_GLB,
    parameter int X_dim             = PSUM_X_DIM,
    parameter int Y_dim             = 3,
    parameter int NUM_ITER          = 3,
    parameter int PSUM_READ_ADDR    = PSUM_READ_ADDR_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_psum_ctrl,
    input  logic [DATA_BITWIDTH-1:0]           r_data_glb_psum,
    output logic [ADDR_BITWIDTH_GLB-1:0]       r_addr_glb_psum,
    output logic                               read_en_glb_psum,
    output logic [DATA_BITWIDTH*X_dim-1:0]     w_data_spad_psum,
    output logic                               psum_load_valid,
    input  logic                               psum_load_ack,
    output logic                               busy
);

    localparam int CW = $clog2(X_dim) + 1;
    localparam int IW = $clog2(NUM_ITER) + 1;
    localparam int AW = ADDR_BITWIDTH_GLB;
    localparam int PW = DATA_BITWIDTH * X_dim;

    if (X_dim < 1 || Y_dim < 1 || NUM_ITER < 1) begin : g_bad_param
        $error("router_psum_load: dimensions must be positive");
    end

    psum_ld_state_e          r_state, w_state_nxt;
    logic                    r_read_en, w_read_en_nxt;
    logic [AW-1:0]           r_addr, w_addr_nxt;
    logic [CW-1:0]           r_issue_cnt, w_issue_cnt_nxt;
    logic [CW-1:0]           r_cap_cnt, w_cap_cnt_nxt;
    logic                    r_cap_en;
    logic [IW-1:0]           r_iter, w_iter_nxt;
    logic                    r_valid, w_valid_nxt;
    logic                    r_busy;
    logic [PW-1:0]           r_data_out, w_data_out_nxt;
    logic [DATA_BITWIDTH-1:0] r_buf [X_dim];
    logic [PW-1:0]           w_packed;
    logic [AW-1:0]           w_base;

    // Row base wraps silently inside the GLB address space.
    assign w_base = AW'(PSUM_READ_ADDR + int'(r_iter) * X_dim);

    // Packed view of the buffer with the in-flight word merged in, so
    // DRAIN can publish the row in the same edge it captures the last psum.
    always_comb begin
        w_packed = '0;
        for (int k = 0; k < X_dim; k++) begin
            w_packed[k*DATA_BITWIDTH +: DATA_BITWIDTH] =
                (r_cap_en && r_cap_cnt == CW'(k)) ? r_data_glb_psum : r_buf[k];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_read_en_nxt   = r_read_en;
        w_addr_nxt      = r_addr;
        w_issue_cnt_nxt = r_issue_cnt;
        w_cap_cnt_nxt   = r_cap_en ? r_cap_cnt + CW'(1) : r_cap_cnt;
        w_iter_nxt      = r_iter;
        w_valid_nxt     = r_valid;
        w_data_out_nxt  = r_data_out;
        unique case (r_state)
            IDLE: begin
                w_read_en_nxt = 1'b0;
                if (load_psum_ctrl) begin
                    w_state_nxt     = READ_GLB;
                    w_read_en_nxt   = 1'b1;
                    w_addr_nxt      = w_base;
                    w_issue_cnt_nxt = CW'(1);
                    w_cap_cnt_nxt   = '0;
                end
            end
            READ_GLB: begin
                if (r_issue_cnt == CW'(X_dim)) begin
                    w_read_en_nxt = 1'b0;
                    w_state_nxt   = DRAIN;
                end else begin
                    w_addr_nxt      = r_addr + AW'(1);
                    w_issue_cnt_nxt = r_issue_cnt + CW'(1);
                end
            end
            DRAIN: begin
                w_data_out_nxt = w_packed;
                w_valid_nxt    = 1'b1;
                w_state_nxt    = PRESENT;
            end
            PRESENT: begin
                if (psum_load_ack) begin
                    w_valid_nxt = 1'b0;
                    w_iter_nxt  = (r_iter == IW'(NUM_ITER - 1)) ?
                                  '0 : r_iter + IW'(1);
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_read_en_nxt = 1'b0;
                w_valid_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_read_en   <= 1'b0;
            r_addr      <= AW'(PSUM_READ_ADDR);
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_cap_en    <= 1'b0;
            r_iter      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_read_en   <= w_read_en_nxt;
            r_addr      <= w_addr_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
            r_cap_cnt   <= w_cap_cnt_nxt;
            // Read data lags the enable by one cycle.
            r_cap_en    <= r_read_en;
            r_iter      <= w_iter_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_data_out  <= w_data_out_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < X_dim; k++) r_buf[k] <= '0;
        end else begin
            for (int k = 0; k < X_dim; k++) begin
                if (r_cap_en && r_cap_cnt == CW'(k))
                    r_buf[k] <= r_data_glb_psum;
            end
        end
    end

    assign r_addr_glb_psum  = r_addr;
    assign read_en_glb_psum = r_read_en;
    assign w_data_spad_psum = r_data_out;
    assign psum_load_valid  = r_valid;
    assign busy             = r_busy;

endmodule

// File: tb/tb_router_psum_load.sv
// Directed bench for router_psum_load with a 1-cycle-latency GLB model.
// Drives loads, stalls, ignored pulses, iteration wrap and mid-read reset.
module tb_router_psum_load;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_psum_ctrl;
    logic [15:0] r_data_glb_psum;
    logic [9:0]  r_addr_glb_psum;
    logic        read_en_glb_psum;
    logic [79:0] w_data_spad_psum;
    logic        psum_load_valid;
    logic        psum_load_ack;
    logic        busy;

    logic [15:0] mem [0:1023];

    int n_tot = 0;
    int n_bad = 0;

    localparam logic [79:0] ROW0 =
        {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
    localparam logic [79:0] ROW1 =
        {16'd100, 16'd90, 16'd80, 16'd70, 16'd60};
    localparam logic [79:0] ROW2 =
        {16'd150, 16'd140, 16'd130, 16'd120, 16'd110};

    router_psum_load dut (
        .clk              (clk),
        .reset            (reset),
        .load_psum_ctrl   (load_psum_ctrl),
        .r_data_glb_psum  (r_data_glb_psum),
        .r_addr_glb_psum  (r_addr_glb_psum),
        .read_en_glb_psum (read_en_glb_psum),
        .w_data_spad_psum (w_data_spad_psum),
        .psum_load_valid  (psum_load_valid),
        .psum_load_ack    (psum_load_ack),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read_en_glb_psum) r_data_glb_psum <= mem[r_addr_glb_psum];
    end

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_state(input string tag);
        chk({tag, "_rden"}, 80'(read_en_glb_psum), 80'(0));
        chk({tag, "_valid"}, 80'(psum_load_valid), 80'(0));
        chk({tag, "_busy"}, 80'(busy), 80'(0));
    endtask

    // One full load: cycle k is the k-th cycle after the start edge.
    task automatic do_load(input string tag, input logic [9:0] base,
                           input logic [79:0] exp, input int dly,
                           input bit poke);
        int nrd;
        nrd = 0;
        load_psum_ctrl = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) load_psum_ctrl = 1'b0;
            chk({tag, "_rden"}, 80'(read_en_glb_psum), 80'(k <= 5));
            if (k <= 5)
                chk({tag, "_addr"}, 80'(r_addr_glb_psum),
                    80'(base + 10'(k - 1)));
            chk({tag, "_valid"}, 80'(psum_load_valid), 80'(k == 7));
            chk({tag, "_busy"}, 80'(busy), 80'(1));
            if (read_en_glb_psum) nrd++;
            if (poke && k == 2) begin
                load_psum_ctrl = 1'b1;
                psum_load_ack  = 1'b1;
            end
            if (poke && k == 3) begin
                load_psum_ctrl = 1'b0;
                psum_load_ack  = 1'b0;
            end
        end
        chk({tag, "_nreads"}, 80'(nrd), 80'(5));
        chk({tag, "_data"}, w_data_spad_psum, exp);
        for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, 80'(psum_load_valid), 80'(1));
            chk({tag, "_stall_data"}, w_data_spad_psum, exp);
            chk({tag, "_stall_rden"}, 80'(read_en_glb_psum), 80'(0));
        end
        psum_load_ack = 1'b1;
        @(negedge clk);
        psum_load_ack = 1'b0;
        idle_state({tag, "_post"});
        chk({tag, "_hold"}, w_data_spad_psum, exp);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'((i + 1) * 10);
        reset           = 1'b1;
        load_psum_ctrl  = 1'b0;
        psum_load_ack   = 1'b0;
        r_data_glb_psum = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_state("rst");
        end
        chk("rst_addr", 80'(r_addr_glb_psum), 80'(0));
        chk("rst_data", w_data_spad_psum, 80'(0));

        do_load("ld0", 10'd0, ROW0, 0, 1'b0);
        do_load("ld1", 10'd5, ROW1, 4, 1'b0);
        do_load("ld2", 10'd10, ROW2, 0, 1'b1);
        do_load("ld3", 10'd0, ROW0, 0, 1'b0);

        // iter is now 1: start at base 5, reset after the third read.
        load_psum_ctrl = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) load_psum_ctrl = 1'b0;
            chk("mid_addr", 80'(r_addr_glb_psum), 80'(10'd5 + 10'(k - 1)));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_state("mid_rst");
        chk("mid_rst_addr", 80'(r_addr_glb_psum), 80'(0));
        chk("mid_rst_data", w_data_spad_psum, 80'(0));
        do_load("ld_after_rst", 10'd0, ROW0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/router_psum_load.md
Name: router_psum_load

Overview:
- Psum load path feeding the PE cluster for accumulation across passes.
- Reads X_dim psums per row from the psum GLB region and packs them into one DATA_BITWIDTH*X_dim word.
- Presents the packed word to the PE cluster's psum scratchpads with a valid/ack handshake.
- Companion of the psum write-back router; consumes the same GLB layout (base + iter*X_dim).

Parameters:
- DATA_BITWIDTH, 16, psum word width
- ADDR_BITWIDTH_GLB, 10, GLB address width
- X_dim, 5, psums per packed row (PE columns)
- Y_dim, 3, PE rows (carried for consistency, unused in logic)
- NUM_ITER, 3, rows per pass before the base address wraps
- PSUM_READ_ADDR, 0, GLB base address of the psum region

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- load_psum_ctrl  in  1  start request, level-sampled in IDLE
- r_data_glb_psum  in  DATA_BITWIDTH  GLB read data, 1-cycle latency
- r_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB read address
- read_en_glb_psum  out  1  GLB read enable
- w_data_spad_psum  out  DATA_BITWIDTH*X_dim  packed psums; slot k = bits [k*DATA_BITWIDTH +: DATA_BITWIDTH]
- psum_load_valid  out  1  packed word valid
- psum_load_ack  in  1  PE cluster accepted the word
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, read_en_glb_psum=0, r_addr_glb_psum=PSUM_READ_ADDR, w_data_spad_psum=0, psum_load_valid=0, busy=0, iter=0, issue/capture counters=0, internal buffer=0.
- All outputs are registered.
- State IDLE:
  - On load_psum_ctrl=1 at edge E0: go to READ_GLB; read_en=1; r_addr=PSUM_READ_ADDR+iter*X_dim, truncated mod 2^ADDR_BITWIDTH_GLB; issue count=1.
  - Otherwise hold; read_en=0.
- State READ_GLB:
  - Each edge: r_addr+=1 and read_en stays 1, until X_dim reads have been issued.
  - Result: read_en is high for exactly X_dim consecutive cycles with addresses base..base+X_dim-1.
  - After the last issue: read_en=0, go to DRAIN.
- Capture rule:
  - Data for a read presented in cycle c is valid in cycle c+1 and is written into buffer slot k at the end of cycle c+1.
  - k = capture count, 0..X_dim-1; slot 0 holds the lowest address.
  - Capture runs in parallel with issuing, one cycle behind.
- State DRAIN: capture the last word. At the same edge, copy the buffer to w_data_spad_psum, set psum_load_valid=1, go to PRESENT.
- Latency: valid rises X_dim+2 cycles after the E0 edge. For X_dim=5, valid is high in cycle 7.
- State PRESENT:
  - psum_load_valid and w_data_spad_psum stay stable until psum_load_ack=1 is sampled.
  - On ack: valid=0, iter=(iter==NUM_ITER-1)?0:iter+1, go to IDLE.
  - w_data_spad_psum keeps its last value after ack.
- Handshake edge cases:
  - Ack sampled outside PRESENT is ignored.
  - Ack may be high in the same cycle valid first rises; the word then transfers in one cycle.
- load_psum_ctrl outside IDLE is ignored; requests are not queued.
- If load_psum_ctrl is still high in IDLE right after an ack, a new load starts at the next edge with the next iter's base.
- Reset mid-operation: abort immediately to reset values; the partial buffer is discarded and iter=0.
- Address wrap: base+offset truncated to ADDR_BITWIDTH_GLB, no error flag.
- Counter width: clog2(X_dim)+1 bits.
- iter width: clog2(NUM_ITER)+1 bits; it never reaches NUM_ITER.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=3'b000, READ_GLB=3'b001, DRAIN=3'b010, PRESENT=3'b011
  - default DATA_BITWIDTH, ADDR_BITWIDTH_GLB, X_dim and PSUM_READ_ADDR, shared with the psum write-back router so both routers use one GLB layout
- No sub-module. The pack buffer is a simple indexed register inside this block.

Test Plan:
- Reset then idle: hold reset 2 cycles, keep load_psum_ctrl=0 for 10 cycles -> read_en=0, valid=0, busy=0, r_addr=0, w_data_spad_psum=0.
- Single load: GLB[0..4]=10,20,30,40,50; pulse load_psum_ctrl; ack immediately:
  - read_en high 5 cycles with r_addr 0..4.
  - valid rises 7 cycles after the start edge.
  - slots 0..4 = 10..50 (bus = {50,40,30,20,10}).
  - valid drops the cycle after ack.
- Stall: delay ack 4 cycles -> w_data_spad_psum and valid stable all 4 cycles; no GLB reads during the stall.
- Iteration/wrap: 4 back-to-back loads with NUM_ITER=3 -> base addresses 0, 5, 10, 0; packed data matches the GLB contents each time.
- Ignored inputs: load_psum_ctrl pulsed during READ_GLB and ack pulsed during READ_GLB -> no restart, no early completion, exactly 5 reads.
- Reset mid-read: assert reset after the 3rd read -> next cycle everything at reset values, iter=0; a following load reads from address 0.
